// File: rtl/main_stack_calc_pkg.sv
// -----------------------------------------------------------------------------
// main_stack_pkg
// Shared definitions for the byte-wide stack calculator.
//   op_e       : 3-bit command code presented on the command interface
//   DEF_WIDTH  : default data width of operands and stack entries
//   DEF_DEPTH  : default number of stack entries (power of two, >= 2)
// -----------------------------------------------------------------------------
package main_stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_POP  = 3'b100,
        OP_PUSH = 3'b101,
        OP_DUP  = 3'b110,
        OP_SWAP = 3'b111
    } op_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/main_stack_calc_if.sv
// -----------------------------------------------------------------------------
// main_stack_calc_if
// Command/status bundle between a command source and the stack calculator.
//   in    : operand for PUSH (master -> slave)
//   op    : 3-bit command code, see main_stack_pkg::op_e (master -> slave)
//   apply : execute op at the next rising clock edge (master -> slave)
//   tail  : current top-of-stack, 0 when empty (slave -> master)
//   empty : stack holds no entries (slave -> master)
//   valid : most recently applied command was legal (slave -> master)
// -----------------------------------------------------------------------------
interface main_stack_calc_if #(
    parameter int WIDTH = main_stack_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] in;
    logic [2:0]       op;
    logic             apply;
    logic [WIDTH-1:0] tail;
    logic             empty;
    logic             valid;

    modport master (
        output in, op, apply,
        input  tail, empty, valid
    );

    modport slave (
        input  in, op, apply,
        output tail, empty, valid
    );
endinterface

// File: rtl/main_stack_calc_alu.sv
// -----------------------------------------------------------------------------
// main_stack_alu
// Combinational arithmetic for the stack calculator. All results wrap modulo
// 2^WIDTH; no carry/overflow flags are produced.
//   a   : top-of-stack entry
//   b   : entry below the top
//   op  : command code; only ADD/SUB/MUL produce a meaningful result
//   res : WIDTH-bit result (b+a, b-a or b*a), 0 for other opcodes
// -----------------------------------------------------------------------------
module main_stack_alu
    import main_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] res
);

    // Full-width product; only the low WIDTH bits are kept.
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] wrap_prod(input logic [2*WIDTH-1:0] p);
        return p[WIDTH-1:0];
    endfunction

    assign prod = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, a};

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = b + a;
            OP_SUB:  res = b - a;
            OP_MUL:  res = wrap_prod(prod);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/main_stack_calc.sv
// -----------------------------------------------------------------------------
// main_stack_calc
// Byte-wide stack calculator accepting one command per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (clears count, entries and valid)
//   bus  : main_stack_calc_if.slave
//            in/op/apply - command, sampled when apply=1
//            tail        - top-of-stack (0 when empty)
//            empty       - stack holds no entries
//            valid       - last applied command was legal
// Build option: define MAIN_STACK_EXT_OPS_EN to enable DUP (110) and
// SWAP (111). Without it both codes are rejected as illegal in all states.
// -----------------------------------------------------------------------------
module main_stack_calc
    import main_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    main_stack_calc_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] entry_p1 [DEPTH];
    logic [CW-1:0]    cnt_p1;
    logic             vld_p1;

    op_e              op_cur;
    logic             legal;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    nxt_idx;
    logic [WIDTH-1:0] alu_res;

    assign op_cur = op_e'(bus.op);

    // Indices wrap inside the array; they are only used when the legality
    // decode guarantees the addressed slot is occupied (or free for a push).
    assign push_idx = cnt_p1[AW-1:0];
    assign top_idx  = cnt_p1[AW-1:0] - AW'(1);
    assign nxt_idx  = cnt_p1[AW-1:0] - AW'(2);

    main_stack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a   (entry_p1[top_idx]),
        .b   (entry_p1[nxt_idx]),
        .op  (op_cur),
        .res (alu_res)
    );

    always_comb begin
        legal = 1'b0;
        case (op_cur)
            OP_NOP:                 legal = 1'b1;
            OP_ADD, OP_SUB, OP_MUL: legal = (cnt_p1 >= CW'(2));
            OP_POP:                 legal = (cnt_p1 != '0);
            OP_PUSH:                legal = (cnt_p1 < CW'(DEPTH));
`ifdef MAIN_STACK_EXT_OPS_EN
            OP_DUP:                 legal = (cnt_p1 != '0) && (cnt_p1 < CW'(DEPTH));
            OP_SWAP:                legal = (cnt_p1 >= CW'(2));
`else
            OP_DUP:                 legal = 1'b0;
            OP_SWAP:                legal = 1'b0;
`endif
            default:                legal = 1'b0;
        endcase
    end

    // ---- stage p1: stack state and legality flag ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1 <= '0;
            vld_p1 <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_p1[i] <= '0;
            end
        end else if (bus.apply) begin
            vld_p1 <= legal;
            if (legal) begin
                case (op_cur)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        entry_p1[nxt_idx] <= alu_res;
                        cnt_p1            <= cnt_p1 - CW'(1);
                    end
                    OP_POP: begin
                        cnt_p1 <= cnt_p1 - CW'(1);
                    end
                    OP_PUSH: begin
                        entry_p1[push_idx] <= bus.in;
                        cnt_p1             <= cnt_p1 + CW'(1);
                    end
`ifdef MAIN_STACK_EXT_OPS_EN
                    OP_DUP: begin
                        entry_p1[push_idx] <= entry_p1[top_idx];
                        cnt_p1             <= cnt_p1 + CW'(1);
                    end
                    OP_SWAP: begin
                        entry_p1[top_idx] <= entry_p1[nxt_idx];
                        entry_p1[nxt_idx] <= entry_p1[top_idx];
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // ---- outputs: combinational decode of p1 state ----
    assign bus.tail  = (cnt_p1 != '0) ? entry_p1[top_idx] : '0;
    assign bus.empty = (cnt_p1 == '0);
    assign bus.valid = vld_p1;

endmodule

// File: tb/tb_main_stack_calc.sv
// -----------------------------------------------------------------------------
// tb_main_stack_calc
// Directed, table-driven bench for main_stack_calc (WIDTH=8, DEPTH=8).
// Vector records carry the command, an optional reset before it, and the
// hand-computed tail/empty/valid expected after the sampling edge.
// Expected values for DUP/SWAP follow MAIN_STACK_EXT_OPS_EN.
// -----------------------------------------------------------------------------
module tb_main_stack_calc;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] MUL  = 3'b011;
    localparam logic [2:0] POP  = 3'b100;
    localparam logic [2:0] PUSH = 3'b101;
    localparam logic [2:0] DUP  = 3'b110;
    localparam logic [2:0] SWAP = 3'b111;

`ifdef MAIN_STACK_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        bit         do_rst;
        logic [2:0] op;
        logic [7:0] in;
        logic [7:0] tail;
        logic       empty;
        logic       valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    main_stack_calc_if #(.WIDTH(8)) bus ();

    main_stack_calc #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] t,
                             input logic e, input logic v);
        check({name, ".tail"},  int'(bus.tail),  int'(t));
        check({name, ".empty"}, int'(bus.empty), int'(e));
        check({name, ".valid"}, int'(bus.valid), int'(v));
    endtask

    // Reset pulse between edges, released well before the next rising edge.
    task automatic do_reset();
        @(negedge clk);
        bus.apply = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // Present a command at the falling edge; it is sampled at the next rising
    // edge and outputs are checked 1 time unit later.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] val);
        @(negedge clk);
        bus.op    = op;
        bus.in    = val;
        bus.apply = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input bit r, input logic [2:0] op, input logic [7:0] val,
                                input logic [7:0] t, input logic e, input logic v);
        vec_t x;
        x.do_rst = r; x.op = op; x.in = val; x.tail = t; x.empty = e; x.valid = v;
        vecs.push_back(x);
    endfunction

    initial begin
        // Group A: basic push/mul/pop sequence
        add(1, PUSH, 8'd2,  8'd2,  0, 1);
        add(0, PUSH, 8'd4,  8'd4,  0, 1);
        add(0, PUSH, 8'd1,  8'd1,  0, 1);
        add(0, MUL,  8'd0,  8'd4,  0, 1);
        add(0, POP,  8'd0,  8'd2,  0, 1);
        add(0, PUSH, 8'd6,  8'd6,  0, 1);
        add(0, PUSH, 8'd37, 8'd37, 0, 1);
        add(0, POP,  8'd0,  8'd6,  0, 1);
        // Group B: wrap-around on ADD and SUB
        add(1, PUSH, 8'd200, 8'd200, 0, 1);
        add(0, PUSH, 8'd100, 8'd100, 0, 1);
        add(0, ADD,  8'd0,   8'd44,  0, 1);
        add(0, PUSH, 8'd50,  8'd50,  0, 1);
        add(0, SUB,  8'd0,   8'd250, 0, 1);
        // Group C: underflow rejections
        add(1, POP,  8'd0, 8'd0, 1, 0);
        add(0, PUSH, 8'd7, 8'd7, 0, 1);
        add(0, ADD,  8'd0, 8'd7, 0, 0);
        add(0, NOP,  8'd0, 8'd7, 0, 1);
        // Group D: fill to DEPTH, overflow rejections
        for (int i = 1; i <= 8; i++) begin
            add(i == 1, PUSH, 8'(i), 8'(i), 0, 1);
        end
        add(0, PUSH, 8'd9, 8'd8,   0, 0);
        add(0, DUP,  8'd0, 8'd8,   0, 0);
        add(0, POP,  8'd0, 8'd7,   0, 1);
        add(0, SUB,  8'd0, 8'd255, 0, 1);   // 6 - 7 wraps
        add(0, MUL,  8'd0, 8'd251, 0, 1);   // 5 * 255 = 1275 mod 256
        // Group E: extended ops
        add(1, PUSH, 8'd3, 8'd3, 0, 1);
        add(0, PUSH, 8'd5, 8'd5, 0, 1);
        add(0, SWAP, 8'd0, EXT ? 8'd3 : 8'd5, 0, EXT);
        add(0, DUP,  8'd0, EXT ? 8'd3 : 8'd5, 0, EXT);
        add(0, ADD,  8'd0, EXT ? 8'd6 : 8'd8, 0, 1);

        bus.in    = '0;
        bus.op    = NOP;
        bus.apply = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 8'd0, 1'b1, 1'b0);
        rst = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].do_rst) begin
                do_reset();
                #1;
                check_out($sformatf("v%0d.pre_rst", k), 8'd0, 1'b1, 1'b0);
            end
            do_cmd(vecs[k].op, vecs[k].in);
            check_out($sformatf("v%0d.op%0d", k, vecs[k].op),
                      vecs[k].tail, vecs[k].empty, vecs[k].valid);
        end
        @(negedge clk);
        bus.apply = 1'b0;

        // apply=0 keeps valid=0 after an illegal command, even with NOP/PUSH on op
        do_reset();
        do_cmd(POP, 8'd0);
        check_out("idle.illegal_pop", 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        bus.apply = 1'b0;
        bus.op    = PUSH;
        bus.in    = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        check_out("idle.hold", 8'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-sequence, observed before any clock edge
        do_cmd(PUSH, 8'd9);
        check_out("arst.push9", 8'd9, 1'b0, 1'b1);
        @(negedge clk);
        bus.apply = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_out("arst.immediate", 8'd0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("arst.hold", 8'd0, 1'b1, 1'b0);

        // Command presented while reset is held across an edge is discarded
        @(negedge clk);
        rst       = 1'b0;
        bus.op    = PUSH;
        bus.in    = 8'd55;
        bus.apply = 1'b1;
        @(posedge clk);
        #1;
        check_out("arst.discard", 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        bus.apply = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("arst.after", 8'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/main_stack_calc.md
# main_stack_calc

Byte-wide stack calculator, module `main_stack_calc`. It accepts one command per clock: push an operand, pop, duplicate, swap, or an arithmetic operation on the top two entries. It exposes the top-of-stack, an empty flag, and a flag saying whether the last applied command was legal. It sits as a standalone leaf datapath, driven by a command source that presents `in`/`op` together with an `apply` strobe.

## Interface
Parameters:
- `WIDTH`, 8: data width of `in`, `tail` and each stack entry.
- `DEPTH`, 8: number of stack entries; must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in`, input, WIDTH: operand for PUSH; ignored for other ops.
- `op`, input, 3: command code.
- `apply`, input, 1: execute `op` at this rising edge when 1.
- `tail`, output, WIDTH: current top-of-stack; 0 when empty.
- `empty`, output, 1: 1 when the stack holds no entries.
- `valid`, output, 1: 1 if the most recently applied command was legal.

## Operation
- Opcodes:
  - 000 NOP
  - 001 ADD
  - 010 SUB
  - 011 MUL
  - 100 POP
  - 101 PUSH
  - 110 DUP
  - 111 SWAP
- State: entry array plus count `cnt` in 0..DEPTH (width clog2(DEPTH)+1).
- For the arithmetic ops, a = top and b = next. The op removes both and pushes the result, so `cnt` decreases by 1. Results:
  - ADD: b+a.
  - SUB: b−a.
  - MUL: b*a.
  - All results are truncated to WIDTH bits (mod 2^WIDTH); there are no flags.
- POP removes the top entry. PUSH stores `in` on top. DUP pushes a copy of the top. SWAP exchanges the top two entries.
- Legality:
  - NOP: always legal.
  - PUSH: requires cnt<DEPTH.
  - POP: requires cnt≥1.
  - DUP: requires 1≤cnt<DEPTH.
  - ADD/SUB/MUL/SWAP: require cnt≥2.
- An illegal command leaves the stack and `cnt` unchanged and clears `valid`. A legal command sets `valid`.
- With `apply`=0, nothing changes, including `valid`.
- `tail` = entry[cnt−1] when cnt>0, else 0. `empty` = (cnt==0). Both are combinational decodes of registered state.

## Timing
- Reset (`rst`=0), asynchronous: cnt=0, `valid`=0, all entries cleared to 0. Outputs: `tail`=0, `empty`=1, `valid`=0.
- A reset asserted mid-sequence aborts immediately; any command presented during reset is discarded.
- Commands are sampled on the rising edge of `clk` when `apply`=1. There is no backpressure, and back-to-back commands on consecutive cycles are fully supported.
- Latency is one edge: `tail`, `empty` and `valid` reflect the command after the edge at which it was sampled.
- Boundary behaviour:
  - PUSH at cnt=DEPTH: rejected.
  - POP at cnt=0: rejected.
  - ADD at cnt=1: rejected; the entry is kept.
- `in`/`op` must be stable around the sampling edge; their values when `apply`=0 are don't-care.

## Configuration
- Macro `MAIN_STACK_EXT_OPS_EN`.
- Defined: DUP (110) and SWAP (111) behave as specified.
- Undefined: 110 and 111 are illegal in all states, i.e. no state change and `valid`←0. All other opcodes are unaffected.

## Structure
- Package `main_stack_pkg` holds:
  - the opcode enum `op_e` (NOP..SWAP, 3 bits);
  - the default `WIDTH`/`DEPTH` localparams.
- One combinational sub-module, `main_stack_alu`. Inputs: a, b, op. Output: the WIDTH-bit result for ADD/SUB/MUL.
- Top level holds the entry array, the count, the legality decode and the `valid` register.

## Test plan
- Reset, then PUSH 2, PUSH 4, PUSH 1, MUL, POP, PUSH 6, PUSH 37, POP. Required `tail` after each command: 2, 4, 1, 4, 2, 6, 37, 6. `valid`=1 throughout; `empty`=0 after the first push.
- PUSH 200, PUSH 100, ADD → `tail`=44 (300 mod 256). Then PUSH 50, SUB → `tail`=250 (44−50 mod 256), `valid`=1.
- Empty stack, POP → `valid`=0, `empty`=1, `tail`=0. Then PUSH 7, ADD → `valid`=0, `tail`=7.
- Fill with 8 PUSHes of 1..8, then PUSH 9 → `valid`=0, `tail`=8. Then DUP → `valid`=0.
- With the macro defined: PUSH 3, PUSH 5, SWAP → `tail`=3; DUP, ADD → `tail`=6. With the macro undefined, SWAP → `valid`=0 and `tail`=5.
- PUSH 9, then pulse `rst` low between edges → `tail`=0, `empty`=1 and `valid`=0 immediately, without waiting for a clock edge. Hold `apply`=0 → outputs remain unchanged.
